// File: rtl/pic_control_gen2.sv
// rtl/pic_control_gen2.sv - 8259-style programmable interrupt controller with rotating priority
// Init word sequencing, edge/level request capture, two-pulse acknowledge and EOI handling.
module pic_control_gen2 #(
  parameter int NUM_IRQ = 8,
  parameter int IDX_W   = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               wr_en,
  input  logic               wr_addr,
  input  logic [15:0]        wr_data,
  input  logic               rd_en,
  input  logic               rd_addr,
  output logic [15:0]        rd_data,
  output logic               int_out,
  input  logic               inta,
  output logic [7:0]         vector,
  output logic               vector_valid
);

  typedef enum logic [1:0] {INIT_READY, W_ICW2, W_ICW3, W_ICW4} init_state_t;
  typedef enum logic {ACK_IDLE, ACK1} ack_state_t;

  init_state_t        init_state;
  ack_state_t         ack_state;
  logic [NUM_IRQ-1:0] imr, irr, isr, irq_q;
  logic [NUM_IRQ-1:0] irr_next, isr_next;
  logic [7:0]         base;
  logic [IDX_W-1:0]   rot_base, ack_idx;
  logic               aeoi, auto_rot, ltim, sngl, ic4, read_isr, ack_spur;

  // Highest-priority set bit of v, scanning upward from rb+1 with wrap; MSB flags "found".
  function automatic logic [IDX_W:0] pick(input logic [NUM_IRQ-1:0] v,
                                          input logic [IDX_W-1:0] rb);
    logic [IDX_W:0]   r;
    logic [IDX_W-1:0] j;
    r = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      j = rb + IDX_W'(k + 1);
      if (v[j]) r = {1'b1, j};
    end
    return r;
  endfunction

  logic [IDX_W:0]   cand_pick, isr_pick;
  logic             cand_found, isr_found, cand_ok;
  logic [IDX_W-1:0] cand_idx, isr_idx, cand_rank, isr_rank;

  assign cand_pick  = pick(irr & ~imr, rot_base);
  assign isr_pick   = pick(isr, rot_base);
  assign cand_found = cand_pick[IDX_W];
  assign cand_idx   = cand_pick[IDX_W-1:0];
  assign isr_found  = isr_pick[IDX_W];
  assign isr_idx    = isr_pick[IDX_W-1:0];
  assign cand_rank  = cand_idx - rot_base - IDX_W'(1);
  assign isr_rank   = isr_idx - rot_base - IDX_W'(1);
  assign cand_ok    = cand_found && (!isr_found || (cand_rank < isr_rank));

  logic             ready, wr_cmd, is_icw1, is_ocw1, is_ocw2, is_ocw3, is_icw_n;
  logic             ns_eoi, sp_eoi, ack_go, ack_fin, aeoi_clr;
  logic [2:0]       ocw2_cmd;
  logic [IDX_W-1:0] lvl;
  logic             unused_ok;

  assign ready     = (init_state == INIT_READY);
  assign wr_cmd    = wr_en && !wr_addr;
  assign is_icw1   = wr_cmd && wr_data[4];
  assign is_ocw2   = wr_cmd && (wr_data[4:3] == 2'b00) && ready;
  assign is_ocw3   = wr_cmd && (wr_data[4:3] == 2'b01) && ready;
  assign is_ocw1   = wr_en && wr_addr && ready;
  assign is_icw_n  = wr_en && wr_addr && !ready;
  assign ocw2_cmd  = wr_data[7:5];
  assign lvl       = wr_data[8 +: IDX_W];
  assign ns_eoi    = is_ocw2 && ((ocw2_cmd == 3'b001) || (ocw2_cmd == 3'b101)) && isr_found;
  assign sp_eoi    = is_ocw2 && ((ocw2_cmd == 3'b011) || (ocw2_cmd == 3'b111));
  assign ack_go    = inta && ready && (ack_state == ACK_IDLE);
  assign ack_fin   = inta && ready && (ack_state == ACK1);
  assign aeoi_clr  = ack_fin && aeoi && !ack_spur;
  assign unused_ok = ^wr_data;

  // EOI clears land before the acknowledge sets, so a same-cycle hit on one bit leaves it set.
  always_comb begin
    isr_next = isr;
    if (ns_eoi) isr_next[isr_idx] = 1'b0;
    if (sp_eoi) isr_next[lvl] = 1'b0;
    if (ack_go && cand_found) isr_next[cand_idx] = 1'b1;
    if (aeoi_clr) isr_next[ack_idx] = 1'b0;
  end

  always_comb begin
    irr_next = irr;
    if (ack_go && cand_found) irr_next[cand_idx] = 1'b0;
    if (ltim) irr_next = irq;
    else      irr_next = irr_next | (irq & ~irq_q);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      init_state   <= INIT_READY;
      ack_state    <= ACK_IDLE;
      imr          <= '1;
      irr          <= '0;
      isr          <= '0;
      irq_q        <= '0;
      base         <= '0;
      rot_base     <= IDX_W'(NUM_IRQ - 1);
      ack_idx      <= '0;
      ack_spur     <= 1'b0;
      aeoi         <= 1'b0;
      auto_rot     <= 1'b0;
      ltim         <= 1'b0;
      sngl         <= 1'b0;
      ic4          <= 1'b0;
      read_isr     <= 1'b0;
      int_out      <= 1'b0;
      vector       <= '0;
      vector_valid <= 1'b0;
      rd_data      <= '0;
    end else begin
      irq_q        <= irq;
      vector_valid <= 1'b0;
      if (rd_en)
        rd_data <= rd_addr ? 16'(imr) : (read_isr ? 16'(isr) : 16'(irr));
      if (is_icw1) begin
        init_state <= W_ICW2;
        ack_state  <= ACK_IDLE;
        ltim       <= wr_data[3];
        sngl       <= wr_data[1];
        ic4        <= wr_data[0];
        imr        <= '0;
        isr        <= '0;
        irr        <= '0;
        aeoi       <= 1'b0;
        auto_rot   <= 1'b0;
        rot_base   <= IDX_W'(NUM_IRQ - 1);
        read_isr   <= 1'b0;
        ack_spur   <= 1'b0;
        int_out    <= 1'b0;
      end else begin
        isr <= isr_next;
        irr <= irr_next;
        if (is_icw_n) begin
          case (init_state)
            W_ICW2: begin
              base <= wr_data[7:0];
              if (!sngl)    init_state <= W_ICW3;
              else if (ic4) init_state <= W_ICW4;
              else          init_state <= INIT_READY;
            end
            W_ICW3: init_state <= ic4 ? W_ICW4 : INIT_READY;
            W_ICW4: begin
              aeoi       <= wr_data[1];
              init_state <= INIT_READY;
            end
            default: ;
          endcase
        end
        if (is_ocw1) imr <= wr_data[NUM_IRQ-1:0];
        if (is_ocw3 && wr_data[1]) read_isr <= wr_data[0];
        if (is_ocw2) begin
          case (ocw2_cmd)
            3'b101:         if (isr_found) rot_base <= isr_idx;
            3'b111, 3'b110: rot_base <= lvl;
            3'b100:         auto_rot <= 1'b1;
            3'b000:         auto_rot <= 1'b0;
            default: ;
          endcase
        end
        if (ack_go) begin
          ack_idx   <= cand_found ? cand_idx : IDX_W'(NUM_IRQ - 1);
          ack_spur  <= !cand_found;
          ack_state <= ACK1;
        end
        if (ack_fin) begin
          vector       <= {base[7:IDX_W], ack_idx};
          vector_valid <= 1'b1;
          ack_state    <= ACK_IDLE;
          if (aeoi && auto_rot && !ack_spur) rot_base <= ack_idx;
        end
        int_out <= ready && (ack_state == ACK_IDLE) && !ack_go && cand_ok;
      end
    end
  end

endmodule

// File: tb/tb_pic_control_gen2.sv
// tb/tb_pic_control_gen2.sv - scoreboard bench for pic_control_gen2 at NUM_IRQ 8 and 16
module tb_pic_control_gen2;

  logic        clk = 1'b0;
  logic        reset_n, sel16;
  logic [15:0] irq, wr_data;
  logic        wr_en, wr_addr, rd_en, rd_addr, inta;
  logic [15:0] rd8, rd16;
  logic        int8, int16, vv8, vv16;
  logic [7:0]  vec8, vec16;
  logic        wr8, wr16, rden8, rden16, inta8, inta16;

  assign wr8    = wr_en & ~sel16;
  assign wr16   = wr_en & sel16;
  assign rden8  = rd_en & ~sel16;
  assign rden16 = rd_en & sel16;
  assign inta8  = inta & ~sel16;
  assign inta16 = inta & sel16;

  always #5 clk = ~clk;

  pic_control_gen2 #(.NUM_IRQ(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .irq(irq[7:0]), .wr_en(wr8), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_en(rden8), .rd_addr(rd_addr), .rd_data(rd8), .int_out(int8),
    .inta(inta8), .vector(vec8), .vector_valid(vv8));

  pic_control_gen2 #(.NUM_IRQ(16)) dut16 (
    .clk(clk), .reset_n(reset_n), .irq(irq), .wr_en(wr16), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_en(rden16), .rd_addr(rd_addr), .rd_data(rd16), .int_out(int16),
    .inta(inta16), .vector(vec16), .vector_valid(vv16));

  int         n_checks = 0;
  int         n_pass   = 0;
  int         vv_count = 0;
  int         vv_mark;
  logic [7:0] exp_q[$];
  logic [7:0] exp_v;
  logic [15:0] q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  always @(negedge clk) begin
    if (vv8 || vv16) begin
      vv_count++;
      if (exp_q.size() == 0) check("vec_unexpected", 1, 0);
      else begin
        exp_v = exp_q.pop_front();
        check("vector", vv16 ? vec16 : vec8, exp_v);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic a, output logic [15:0] d);
    rd_en = 1'b1; rd_addr = a;
    tick();
    rd_en = 1'b0;
    d = sel16 ? rd16 : rd8;
  endtask

  task automatic pulse(input logic [15:0] m);
    irq = m;
    tick();
    irq = '0;
    tick();
  endtask

  task automatic ack_pair();
    inta = 1'b1; tick(); inta = 1'b0; tick();
    inta = 1'b1; tick(); inta = 1'b0; tick();
  endtask

  task automatic init(input logic [7:0] b, input logic [7:0] icw4);
    wr(1'b0, 16'h0013);
    wr(1'b1, {8'h00, b});
    wr(1'b1, {8'h00, icw4});
    wr(1'b1, 16'h0000);
  endtask

  function automatic logic int_now();
    return sel16 ? int16 : int8;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; sel16 = 1'b0; irq = '0; wr_data = '0;
    wr_en = 1'b0; wr_addr = 1'b0; rd_en = 1'b0; rd_addr = 1'b0; inta = 1'b0;
    tick(); tick();
    check("rst_int8", int8, 0);
    check("rst_int16", int16, 0);
    check("rst_vv", {vv8, vv16}, 0);
    check("rst_vec8", vec8, 0);
    check("rst_rd8", rd8, 0);
    reset_n = 1'b1;
    rd(1'b1, q); check("rst_imr8", q, 16'h00ff);
    rd(1'b0, q); check("rst_irr8", q, 0);
    sel16 = 1'b1;
    rd(1'b1, q); check("rst_imr16", q, 16'hffff);
    sel16 = 1'b0;

    // Basic edge-triggered request and acknowledge
    init(8'h40, 8'h01);
    rd(1'b1, q); check("icw1_imr", q, 0);
    pulse(16'h0008);
    check("irq3_int", int_now(), 1);
    exp_q.push_back(8'h43);
    ack_pair();
    check("irq3_int_drop", int_now(), 0);
    wr(1'b0, 16'h000b);
    rd(1'b0, q); check("irq3_isr", q, 16'h0008);
    wr(1'b0, 16'h0020);
    rd(1'b0, q); check("ns_eoi_isr", q, 0);

    // Higher-priority in-service level blocks a lower request until specific EOI
    pulse(16'h0002);
    exp_q.push_back(8'h41);
    ack_pair();
    pulse(16'h0010);
    tick(); tick();
    check("blocked_int", int_now(), 0);
    wr(1'b0, 16'h000a);
    rd(1'b0, q); check("blocked_irr", q, 16'h0010);
    wr(1'b0, 16'h0160);
    tick();
    check("after_seoi_int", int_now(), 1);
    exp_q.push_back(8'h44);
    ack_pair();
    wr(1'b0, 16'h0020);

    // Spurious acknowledge leaves ISR alone
    pulse(16'h0004);
    exp_q.push_back(8'h42);
    ack_pair();
    wr(1'b1, 16'h00ff);
    pulse(16'h0040);
    check("masked_int", int_now(), 0);
    exp_q.push_back(8'h47);
    ack_pair();
    wr(1'b0, 16'h000b);
    rd(1'b0, q); check("spur_isr", q, 16'h0004);

    // Reset between the two acknowledge pulses abandons the sequence
    vv_mark = vv_count;
    inta = 1'b1; tick(); inta = 1'b0;
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    inta = 1'b1; tick(); inta = 1'b0;
    tick(); tick(); tick();
    check("midack_vv", vv_count, vv_mark);
    check("midack_int", int_now(), 0);
    rd(1'b1, q); check("midack_imr", q, 16'h00ff);

    // Automatic EOI with automatic rotation
    init(8'h40, 8'h03);
    wr(1'b0, 16'h0080);
    pulse(16'h0024);
    check("rot_int", int_now(), 1);
    exp_q.push_back(8'h42);
    exp_q.push_back(8'h45);
    ack_pair();
    ack_pair();
    wr(1'b0, 16'h000b);
    rd(1'b0, q); check("aeoi_isr", q, 0);
    pulse(16'h0050);
    exp_q.push_back(8'h46);
    exp_q.push_back(8'h44);
    ack_pair();
    ack_pair();

    // Sixteen-line instance
    sel16 = 1'b1;
    init(8'h80, 8'h01);
    pulse(16'h2000);
    check("irq13_int", int_now(), 1);
    exp_q.push_back(8'h8d);
    ack_pair();
    wr(1'b0, 16'h000b);
    rd(1'b0, q); check("irq13_isr", q, 16'h2000);
    wr(1'b0, 16'h0020);
    rd(1'b0, q); check("irq13_eoi_isr", q, 0);

    tick(); tick();
    check("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
